// File: rtl/transconv_pkg.sv
// Shared types and widths for the stride-2 transposed-convolution sequencer and datapath.
package transconv_pkg;

  localparam int unsigned CW     = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PIX_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/transconv_seq.sv
// Sequencer for the transconv line-buffer datapath: alternates accumulate (write) and
// readout phases over an HxW input map, producing a (2H+1)x(2W+1) output map.
module transconv_seq #(
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned CW           = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [7:0]                        cfg_width,
  input  logic [7:0]                        cfg_height,
  input  logic [transconv_pkg::DATA_W-1:0]  cfg_bias,
  input  logic [transconv_pkg::DATA_W-1:0]  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [transconv_pkg::DATA_W-1:0]  dp_in,
  output logic [transconv_pkg::DATA_W-1:0]  dp_bias,
  output logic                              dp_rw,
  output logic                              dp_hop,
  output logic                              dp_flip,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              done
);

  import transconv_pkg::*;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CW-1:0]       r_col;
  logic [CW-1:0]       w_col_nxt;
  logic [CW-1:0]       r_row;
  logic [CW-1:0]       w_row_nxt;
  logic [CW-1:0]       r_w;
  logic [CW-1:0]       r_h;
  logic                r_sub;
  logic                w_sub_nxt;
  logic                r_flip;
  logic                w_flip_nxt;
  logic [DATA_W-1:0]   r_bias;
  logic                r_in_ready;
  logic                r_dp_rw;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;

  logic [CW-1:0]       w_cfg_w;
  logic [CW-1:0]       w_cfg_h;
  logic                w_accept;
  logic                w_wr_last;
  logic                w_rd_last;

  // Out-of-range geometry saturates to the datapath's line-buffer size.
  assign w_cfg_w = (32'(cfg_width)  > IMAGE_WIDTH)  ? CW'(IMAGE_WIDTH)  : CW'(cfg_width);
  assign w_cfg_h = (32'(cfg_height) > IMAGE_HEIGHT) ? CW'(IMAGE_HEIGHT) : CW'(cfg_height);

  assign w_accept  = r_in_ready & in_valid;
  assign w_wr_last = (r_col == r_w - CW'(1));
  // A readout row is 2W+1 cycles; S_READ covers two of them, tracked by r_sub.
  assign w_rd_last = (r_col == CW'(r_w << 1));

  // Next-state and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_sub_nxt   = r_sub;
    w_flip_nxt  = r_flip;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_sub_nxt   = 1'b0;
          w_flip_nxt  = 1'b0;
          w_state_nxt = ((w_cfg_w == '0) || (w_cfg_h == '0)) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          if (w_wr_last) begin
            w_col_nxt   = '0;
            w_state_nxt = S_READ;
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      S_READ: begin
        if (w_rd_last) begin
          w_col_nxt = '0;
          if (r_sub) begin
            w_sub_nxt   = 1'b0;
            w_flip_nxt  = ~r_flip;
            w_row_nxt   = r_row + CW'(1);
            w_state_nxt = ((r_row + CW'(1)) < r_h) ? S_WRITE : S_FLUSH;
          end else begin
            w_sub_nxt = 1'b1;
          end
        end else begin
          w_col_nxt = r_col + CW'(1);
        end
      end
      S_FLUSH: begin
        if (w_rd_last) begin
          w_col_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_col_nxt = r_col + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, latched config and registered phase outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_sub       <= 1'b0;
      r_flip      <= 1'b0;
      r_w         <= '0;
      r_h         <= '0;
      r_bias      <= '0;
      r_in_ready  <= 1'b0;
      r_dp_rw     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_sub   <= w_sub_nxt;
      r_flip  <= w_flip_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_w    <= w_cfg_w;
        r_h    <= w_cfg_h;
        r_bias <= cfg_bias;
      end
      r_in_ready  <= (w_state_nxt == S_WRITE);
      r_dp_rw     <= !((w_state_nxt == S_READ) || (w_state_nxt == S_FLUSH));
      r_busy      <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ) ||
                     (w_state_nxt == S_FLUSH);
      r_done      <= (w_state_nxt == S_DONE);
      // The datapath pixel register makes output data lag the read cycle by one.
      r_out_valid <= (r_state == S_READ) || (r_state == S_FLUSH);
    end
  end

  // Beat-qualified datapath inputs: stalls feed zeros so nothing is accumulated.
  assign dp_in     = w_accept ? in_data : '0;
  assign dp_bias   = w_accept ? r_bias  : '0;
  assign dp_hop    = w_accept;
  assign in_ready  = r_in_ready;
  assign dp_rw     = r_dp_rw;
  assign dp_flip   = r_flip;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_transconv_seq.sv
// Scoreboard bench for transconv_seq: expected beats, read phases and frame totals are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_transconv_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] cfg_width;
  logic [7:0] cfg_height;
  logic [7:0] cfg_bias;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dp_in;
  logic [7:0] dp_bias;
  logic       dp_rw;
  logic       dp_hop;
  logic       dp_flip;
  logic       out_valid;
  logic       busy;
  logic       done;

  transconv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bias(cfg_bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dp_in(dp_in), .dp_bias(dp_bias), .dp_rw(dp_rw), .dp_hop(dp_hop),
    .dp_flip(dp_flip), .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [7:0] b; } beat_t;
  typedef struct { int len; bit flip; } phase_t;
  typedef struct { int beats; int pix; bit no_rdy; } frame_t;

  beat_t  beat_q[$];
  phase_t phase_q[$];
  frame_t frame_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int rw_falls = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  // ---------------- monitor ----------------
  int  m_run;
  bit  m_run_flip;
  int  m_beats;
  int  m_pix;
  int  m_rdy;
  bit  m_prev_busy;
  bit  m_prev_rw;

  function automatic void close_run();
    phase_t p;
    if (phase_q.size() == 0) begin
      fail_now("unexpected_read_phase");
    end else begin
      p = phase_q.pop_front();
      chk("phase_len", longint'(m_run), longint'(p.len));
      chk("phase_flip", longint'(m_run_flip), longint'(p.flip));
    end
    m_run = 0;
  endfunction

  always @(negedge clk) begin
    beat_t  bt;
    frame_t fr;
    if (!rst_n) begin
      beat_q.delete();
      phase_q.delete();
      frame_q.delete();
      m_run = 0; m_beats = 0; m_pix = 0; m_rdy = 0;
      m_prev_busy = 1'b0; m_prev_rw = 1'b1;
    end else begin
      chk("out_valid_lag", longint'(out_valid), longint'(m_prev_busy && !m_prev_rw));
      if (dp_hop) begin
        m_beats++;
        if (beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          bt = beat_q.pop_front();
          chk("beat_data_bias", longint'({dp_in, dp_bias}), longint'({bt.d, bt.b}));
        end
      end else if (busy) begin
        chk("stall_zero", longint'({dp_in, dp_bias}), 0);
      end
      if (out_valid) m_pix++;
      if (in_ready)  m_rdy++;
      if (m_prev_rw && !dp_rw) rw_falls++;
      if (!dp_rw && busy) begin
        if (m_run > 0 && dp_flip != m_run_flip) close_run();
        if (m_run == 0) m_run_flip = dp_flip;
        m_run++;
      end else if (m_run > 0) begin
        close_run();
      end
      if (done) begin
        chk("busy_low_at_done", longint'(busy), 0);
        if (frame_q.size() == 0) fail_now("unexpected_done");
        else begin
          fr = frame_q.pop_front();
          chk("frame_beats", longint'(m_beats), longint'(fr.beats));
          chk("frame_pixels", longint'(m_pix), longint'(fr.pix));
          if (fr.no_rdy) chk("frame_no_ready", longint'(m_rdy), 0);
        end
        m_beats = 0; m_pix = 0; m_rdy = 0;
      end
      m_prev_busy = busy;
      m_prev_rw   = dp_rw;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    logic [4:0] quiet;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        longint'({in_ready, dp_in, dp_bias, dp_rw, dp_hop, dp_flip, out_valid, busy, done}), 0);
    chk("abort_flip_zero", longint'(dp_flip), 0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    quiet = '0;
    repeat (8) begin
      tick();
      quiet = quiet | {out_valid, done, busy, in_ready, dp_hop};
    end
    chk("post_abort_quiet", longint'(quiet), 0);
  endtask

  task automatic run_frame(input int w, input int h, input int bias,
                           input bit stall, input bit repulse, input bit abort);
    int ws;
    int hs;
    int n;
    int base;
    bit acc;
    bit deg;
    ws  = (w > 128) ? 128 : w;
    hs  = (h > 128) ? 128 : h;
    deg = (ws == 0) || (hs == 0);
    frame_q.push_back('{beats: deg ? 0 : ws * hs,
                        pix: deg ? 0 : (2 * hs + 1) * (2 * ws + 1), no_rdy: deg});
    if (!deg) begin
      for (int r = 0; r < hs; r++) phase_q.push_back('{len: 4 * ws + 2, flip: bit'(r % 2)});
      phase_q.push_back('{len: 2 * ws + 1, flip: bit'(hs % 2)});
      for (int i = 0; i < ws * hs; i++) beat_q.push_back('{d: 8'(i * 7 + 3), b: 8'(bias)});
    end
    base       = rw_falls;
    start      = 1'b1;
    cfg_width  = 8'(w);
    cfg_height = 8'(h);
    cfg_bias   = 8'(bias);
    tick();
    start = 1'b0;
    if (deg) chk("degenerate_done_latency", longint'(done), 1);
    for (int i = 0; i < ws * hs; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 7 + 3);
      n   = 0;
      acc = 1'b0;
      while (!acc) begin
        if (abort && (rw_falls - base) == 2 && !dp_rw) begin
          do_abort();
          return;
        end
        if (n >= 2000) begin
          fail_now("beat_accept_timeout");
          in_valid = 1'b0;
          return;
        end
        acc = in_ready;
        if (repulse && i == 3 && n == 0) begin
          start     = 1'b1;
          cfg_width = 8'd7;
        end
        tick();
        start = 1'b0;
        n++;
      end
      in_valid = 1'b0;
      if (stall) begin
        in_data = 8'hA5;
        tick();
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h3C;
    n = 0;
    while (!done) begin
      if (n >= 100000) begin
        fail_now("done_timeout");
        return;
      end
      if (repulse && n == 5) begin
        start     = 1'b1;
        cfg_width = 8'd2;
      end
      tick();
      start = 1'b0;
      n++;
    end
    tick();
    chk("done_single_pulse", longint'(done), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_bias   = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    repeat (3) tick();
    chk("reset_outputs_zero",
        longint'({in_ready, dp_in, dp_bias, dp_rw, dp_hop, dp_flip, out_valid, busy, done}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_rw_high", longint'(dp_rw), 1);
    chk("idle_not_busy", longint'({busy, in_ready}), 0);

    run_frame(4, 2, -3, 1'b0, 1'b0, 1'b0);
    run_frame(4, 1, 5, 1'b1, 1'b0, 1'b0);
    run_frame(0, 5, 9, 1'b0, 1'b0, 1'b0);
    run_frame(8, 4, 1, 1'b0, 1'b0, 1'b1);
    run_frame(8, 4, -128, 1'b0, 1'b0, 1'b0);
    run_frame(4, 2, 17, 1'b0, 1'b1, 1'b0);
    run_frame(255, 3, 2, 1'b0, 1'b0, 1'b0);
    run_frame(1, 200, -1, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("leftover_beats", longint'(beat_q.size()), 0);
    chk("leftover_phases", longint'(phase_q.size()), 0);
    chk("leftover_frames", longint'(frame_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
